// File: rtl/axi_mem_responder_pkg.sv
// Shared types and sizing for the AXI memory responder and its burst counters.
package axi_mem_responder_pkg;

  localparam int unsigned AXI_ID_WIDTH      = 4;
  localparam int unsigned AXI_LEN_WIDTH     = 8;
  localparam int unsigned AXI_ADDR_WIDTH    = 32;
  localparam int unsigned AXI_DATA_WIDTH    = 32;
  localparam int unsigned DEFAULT_MAX_BURST = 16;
  localparam int unsigned BURST_CNT_WIDTH   = $clog2(DEFAULT_MAX_BURST + 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} resp_wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} resp_rstate_t;

  // AxLEN counts beats, so zero or anything above the burst limit is malformed.
  function automatic logic len_illegal(input logic [AXI_LEN_WIDTH-1:0] len,
                                       input int unsigned max_burst);
    return (len == '0) || (32'(len) > max_burst);
  endfunction

endpackage

// File: rtl/axi_mem_responder_burst_counter.sv
// Loadable word-index register with a beat counter; flags the final beat of a burst.
module axi_burst_counter
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned IDX_W = 16,
  parameter int unsigned CNT_W = BURST_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    len_d = len_q;
    if (load_i) begin
      idx_d = idx_i;
      cnt_d = '0;
      len_d = len_i;
    end else if (step_i) begin
      idx_d = idx_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (CNT_W'(cnt_q + 1'b1) == len_q);

endmodule

// File: rtl/axi_mem_responder.sv
// AXI-style slave memory model with independent write and read burst FSMs.
module axi_mem_responder
  import axi_mem_responder_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned MAX_BURST      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write_address_awvalid_i,
  input  logic [3:0]  mem_write_address_awid_i,
  input  logic [7:0]  mem_write_address_awlen_i,
  input  logic [31:0] mem_write_address_awaddr_i,
  output logic        mem_write_address_awready_o,
  input  logic        mem_write_data_wvalid_i,
  input  logic [3:0]  mem_write_data_wid_i,
  input  logic [31:0] mem_write_data_wdata_i,
  input  logic        mem_write_data_wlast_i,
  output logic        mem_write_data_wready_o,
  input  logic        mem_write_response_bready_i,
  output logic        mem_write_response_bvalid_o,
  output logic [3:0]  mem_write_response_bid_o,
  input  logic        mem_read_address_arvalid_i,
  input  logic [3:0]  mem_read_address_arid_i,
  input  logic [7:0]  mem_read_address_arlen_i,
  input  logic [31:0] mem_read_address_araddr_i,
  output logic        mem_read_address_arready_o,
  input  logic        mem_read_data_rready_i,
  output logic        mem_read_data_rvalid_o,
  output logic [3:0]  mem_read_data_rid_o,
  output logic [31:0] mem_read_data_rdata_o,
  output logic        mem_read_data_rlast_o,
  output logic        protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;

  logic [31:0] mem_q [DEPTH];

  resp_wstate_t w_state_q, w_state_d;
  resp_rstate_t r_state_q, r_state_d;
  logic [3:0]   awid_q, awid_d, arid_q, arid_d, wait_q, wait_d;
  logic         err_q, err_d, w_err, r_err;
  logic         w_load, w_step, w_last, r_load, r_step, r_last;
  logic [MEM_ADDR_WIDTH-1:0] w_idx, r_idx;

  function automatic logic [CNT_W-1:0] clamp_len(input logic [7:0] len);
    if (len == '0) return CNT_W'(1);
    if (32'(len) > MAX_BURST) return CNT_W'(MAX_BURST);
    return CNT_W'(len);
  endfunction

  axi_burst_counter #(.IDX_W(MEM_ADDR_WIDTH), .CNT_W(CNT_W)) u_wcnt (
    .clk(clk), .rst(rst), .load_i(w_load), .step_i(w_step),
    .idx_i(mem_write_address_awaddr_i[MEM_ADDR_WIDTH+1:2]),
    .len_i(clamp_len(mem_write_address_awlen_i)), .idx_o(w_idx), .last_o(w_last)
  );

  axi_burst_counter #(.IDX_W(MEM_ADDR_WIDTH), .CNT_W(CNT_W)) u_rcnt (
    .clk(clk), .rst(rst), .load_i(r_load), .step_i(r_step),
    .idx_i(mem_read_address_araddr_i[MEM_ADDR_WIDTH+1:2]),
    .len_i(clamp_len(mem_read_address_arlen_i)), .idx_o(r_idx), .last_o(r_last)
  );

  // The beat counter alone ends a write burst; WLAST is only checked for consistency.
  always_comb begin
    w_state_d                   = w_state_q;
    awid_d                      = awid_q;
    w_load                      = 1'b0;
    w_step                      = 1'b0;
    w_err                       = 1'b0;
    mem_write_address_awready_o = 1'b0;
    mem_write_data_wready_o     = 1'b0;
    mem_write_response_bvalid_o = 1'b0;
    mem_write_response_bid_o    = '0;
    case (w_state_q)
      W_IDLE: begin
        mem_write_address_awready_o = !rst;
        if (mem_write_address_awvalid_i) begin
          w_load    = 1'b1;
          awid_d    = mem_write_address_awid_i;
          w_err     = len_illegal(mem_write_address_awlen_i, MAX_BURST);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        mem_write_data_wready_o = 1'b1;
        if (mem_write_data_wvalid_i) begin
          w_step = 1'b1;
          w_err  = (mem_write_data_wlast_i != w_last);
          if (w_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        mem_write_response_bvalid_o = 1'b1;
        mem_write_response_bid_o    = awid_q;
        if (mem_write_response_bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d                  = r_state_q;
    arid_d                     = arid_q;
    wait_d                     = wait_q;
    r_load                     = 1'b0;
    r_step                     = 1'b0;
    r_err                      = 1'b0;
    mem_read_address_arready_o = 1'b0;
    mem_read_data_rvalid_o     = 1'b0;
    mem_read_data_rid_o        = '0;
    mem_read_data_rdata_o      = '0;
    mem_read_data_rlast_o      = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        mem_read_address_arready_o = !rst;
        if (mem_read_address_arvalid_i) begin
          r_load    = 1'b1;
          arid_d    = mem_read_address_arid_i;
          wait_d    = 4'(READ_LATENCY - 1);
          r_err     = len_illegal(mem_read_address_arlen_i, MAX_BURST);
          r_state_d = (READ_LATENCY == 0) ? R_DATA : R_WAIT;
        end
      end
      R_WAIT: begin
        if (wait_q == '0) r_state_d = R_DATA;
        else              wait_d    = wait_q - 1'b1;
      end
      R_DATA: begin
        mem_read_data_rvalid_o = 1'b1;
        mem_read_data_rid_o    = arid_q;
        mem_read_data_rdata_o  = mem_q[r_idx];
        mem_read_data_rlast_o  = r_last;
        if (mem_read_data_rready_i) begin
          r_step = 1'b1;
          if (r_last) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign err_d = err_q | w_err | r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awid_q    <= '0;
      arid_q    <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awid_q    <= awid_d;
      arid_q    <= arid_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_step) mem_q[w_idx] <= mem_write_data_wdata_i;
  end

  assign protocol_err_o = err_q;

  logic unused_bits;
  assign unused_bits = ^{mem_write_data_wid_i,
                         mem_write_address_awaddr_i[31:MEM_ADDR_WIDTH+2], mem_write_address_awaddr_i[1:0],
                         mem_read_address_araddr_i[31:MEM_ADDR_WIDTH+2], mem_read_address_araddr_i[1:0]};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed and randomized bursts checked against an associative-array memory model.
module tb_axi_mem_responder;

  localparam int AW    = 16;
  localparam int LAT   = 4;
  localparam int MAXB  = 16;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0, rst = 1'b1;
  logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic [3:0]  awid = 0, wid = 0, arid = 0;
  logic [7:0]  awlen = 0, arlen = 0;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0;
  logic        awready, wready, bvalid, arready, rvalid, rlast, perr;
  logic [3:0]  bid, rid;
  logic [31:0] rdata;

  int          n_assert = 0, n_fail = 0;
  logic [31:0] model [int];
  logic [31:0] wbuf [MAXB];
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  axi_mem_responder #(.MEM_ADDR_WIDTH(AW), .READ_LATENCY(LAT), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .mem_write_address_awvalid_i(awvalid), .mem_write_address_awid_i(awid),
    .mem_write_address_awlen_i(awlen), .mem_write_address_awaddr_i(awaddr),
    .mem_write_address_awready_o(awready),
    .mem_write_data_wvalid_i(wvalid), .mem_write_data_wid_i(wid),
    .mem_write_data_wdata_i(wdata), .mem_write_data_wlast_i(wlast),
    .mem_write_data_wready_o(wready),
    .mem_write_response_bready_i(bready), .mem_write_response_bvalid_o(bvalid),
    .mem_write_response_bid_o(bid),
    .mem_read_address_arvalid_i(arvalid), .mem_read_address_arid_i(arid),
    .mem_read_address_arlen_i(arlen), .mem_read_address_araddr_i(araddr),
    .mem_read_address_arready_o(arready),
    .mem_read_data_rready_i(rready), .mem_read_data_rvalid_o(rvalid),
    .mem_read_data_rid_o(rid), .mem_read_data_rdata_o(rdata),
    .mem_read_data_rlast_o(rlast), .protocol_err_o(perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input logic [7:0] len);
    if (len == 0) return 1;
    if (int'(len) > MAXB) return MAXB;
    return int'(len);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awready"}, 32'(awready), 0);
    chk({tag, "_arready"}, 32'(arready), 0);
    chk({tag, "_wready"},  32'(wready), 0);
    chk({tag, "_bvalid"},  32'(bvalid), 0);
    chk({tag, "_rvalid"},  32'(rvalid), 0);
    chk({tag, "_rlast"},   32'(rlast), 0);
    chk({tag, "_rdata"},   rdata, 0);
    chk({tag, "_rid"},     32'(rid), 0);
    chk({tag, "_bid"},     32'(bid), 0);
    chk({tag, "_perr"},    32'(perr), 0);
  endtask

  // wlast_beat < 0 means WLAST on the true final beat.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input int wlast_beat, input bit gaps);
    int n, base, i, hold;
    n    = eff_len(len);
    base = int'(addr[AW+1:2]);
    if (len == 0 || int'(len) > MAXB) exp_err = 1'b1;
    @(negedge clk);
    chk("awready_idle", 32'(awready), 1);
    awvalid = 1; awaddr = addr; awlen = len; awid = id;
    @(negedge clk);
    awvalid = 0;
    chk("awready_busy", 32'(awready), 0);
    chk("wready_after_aw", 32'(wready), 1);
    i = 0;
    while (i < n) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 0;
        @(negedge clk);
      end else begin
        chk("wready_beat", 32'(wready), 1);
        wvalid = 1; wid = id; wdata = wbuf[i];
        wlast  = (wlast_beat < 0) ? (i == n - 1) : (i == wlast_beat);
        if (wlast != (i == n - 1)) exp_err = 1'b1;
        model[(base + i) % DEPTH] = wbuf[i];
        @(negedge clk);
        i++;
      end
    end
    wvalid = 0; wlast = 0;
    chk("wready_done", 32'(wready), 0);
    hold = gaps ? int'($urandom_range(0, 2)) : 0;
    for (int k = 0; k <= hold; k++) begin
      chk("bvalid", 32'(bvalid), 1);
      chk("bid", 32'(bid), 32'(id));
      if (k == hold) bready = 1;
      @(negedge clk);
    end
    bready = 0;
    chk("bvalid_done", 32'(bvalid), 0);
    chk("awready_back", 32'(awready), 1);
    chk("protocol_err_w", 32'(perr), 32'(exp_err));
  endtask

  // mode 0: RREADY always high, 1: pattern 1,0,0,..., 2: random.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                         input int mode);
    int n, base, cyc, beat, k;
    logic rr;
    n    = eff_len(len);
    base = int'(addr[AW+1:2]);
    if (len == 0 || int'(len) > MAXB) exp_err = 1'b1;
    @(negedge clk);
    chk("arready_idle", 32'(arready), 1);
    arvalid = 1; araddr = addr; arlen = len; arid = id; rready = 0;
    @(negedge clk);
    arvalid = 0;
    chk("arready_busy", 32'(arready), 0);
    cyc = 1;
    while (!rvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("r_latency", 32'(cyc), 32'(LAT + 1));
    beat = 0; k = 0;
    while (beat < n && k < 400) begin
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (k % 3 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      k++;
      chk("rvalid", 32'(rvalid), 1);
      chk("rdata", rdata, model[(base + beat) % DEPTH]);
      chk("rlast", 32'(rlast), 32'(beat == n - 1));
      chk("rid", 32'(rid), 32'(id));
      rready = rr;
      @(negedge clk);
      if (rr) beat++;
    end
    rready = 0;
    chk("r_beats", 32'(beat), 32'(n));
    chk("rvalid_done", 32'(rvalid), 0);
    chk("arready_back", 32'(arready), 1);
    chk("protocol_err_r", 32'(perr), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    // reset values
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 0;

    // basic write then reads
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(32'h40, 4, 0, -1, 0);
    chk("mem_10", model[16'h10], 32'hA0);
    do_read(32'h40, 4, 8, 0);
    do_read(32'h40, 4, 8, 1);

    // wrap at the top of the backing store; upper address bits ignored
    for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
    a = 32'((DEPTH - 2) * 4);
    do_write(a, 4, 5, -1, 0);
    do_read(a | 32'h8000_0000, 4, 6, 0);
    do_read(32'h0, 2, 7, 0);

    // malformed bursts: early WLAST, zero length, oversize length
    for (int i = 0; i < MAXB; i++) wbuf[i] = 32'hB000 + 32'(i);
    do_write(32'h100, 4, 1, 1, 0);
    chk("err_sticky", 32'(perr), 1);
    do_write(32'h200, 0, 2, -1, 0);
    do_write(32'h300, 20, 3, -1, 0);
    do_read(32'h100, 4, 1, 0);
    do_read(32'h200, 0, 2, 0);
    do_read(32'h300, 16, 3, 2);
    chk("err_still_set", 32'(perr), 1);

    // reset during beat 2 of a read
    @(negedge clk);
    arvalid = 1; araddr = 32'h100; arlen = 4; arid = 4'h9;
    @(negedge clk);
    arvalid = 0;
    for (int c = 0; c < 20 && !rvalid; c++) @(negedge clk);
    rready = 1;
    @(negedge clk);
    rready = 0;
    #1 rst = 1;
    #1 chk_all_zero("rst_read");
    @(negedge clk);
    rst = 0; exp_err = 0;
    for (int c = 0; c < 8; c++) begin
      chk("no_r_after_rst", 32'(rvalid), 0);
      @(negedge clk);
    end

    // reset during beat 2 of a write
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1;
    awvalid = 1; awaddr = 32'h500; awlen = 4; awid = 4'h4;
    @(negedge clk);
    awvalid = 0; wvalid = 1; wdata = wbuf[0]; wlast = 0;
    model[32'h140] = wbuf[0];
    @(negedge clk);
    wdata = wbuf[1];
    #1 rst = 1;
    #1 chk_all_zero("rst_write");
    @(negedge clk);
    wvalid = 0; rst = 0;
    for (int c = 0; c < 4; c++) begin
      chk("no_b_after_rst", 32'(bvalid), 0);
      @(negedge clk);
    end
    do_read(32'h500, 1, 4'hA, 0);
    for (int i = 0; i < 2; i++) wbuf[i] = 32'hD0 + 32'(i);
    do_write(32'h600, 2, 4'hB, -1, 0);
    do_read(32'h600, 2, 4'hC, 0);

    // randomized legal bursts
    for (int t = 0; t < 24; t++) begin
      a = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 13'($urandom), 16'($urandom), 2'b00};
      l = 8'($urandom_range(1, MAXB));
      for (int i = 0; i < MAXB; i++) wbuf[i] = $urandom;
      do_write(a, l, 4'($urandom), -1, 1);
      do_read(a, l, 4'($urandom), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
